inst_encoder: RTL

Sequential MIPS instruction encoder and instruction-memory loader. It accepts a stream of decoded instruction commands (class plus register/immediate fields) over a valid/ready handshake, assembles the 32-bit MIPS word, and writes it to consecutive instruction-memory word addresses. It sits between the test/boot host and the instruction memory of the pipeline CPU, producing the exact opcode patterns the main decoder consumes. Branch targets are given as absolute word addresses and converted to PC-relative offsets.

---
 rtl/inst_encoder.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/inst_encoder.sv
// inst_encoder: assembles MIPS instruction words from decoded command fields
// and streams them into consecutive instruction-memory word addresses.
// Optional build macro INST_ENC_RANGE_CHECK_EN: a branch whose PC-relative
// offset does not fit in 16 bits is replaced by a NOP and flags err.
// Without it the offset is silently truncated and err is constant 0.
module inst_encoder #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_kind,
  input  logic [4:0]        cmd_rs,
  input  logic [4:0]        cmd_rt,
  input  logic [4:0]        cmd_rd,
  input  logic [5:0]        cmd_funct,
  input  logic [25:0]       cmd_imm,
  input  logic              cmd_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ovf,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  localparam logic [3:0] K_R    = 4'd0,  K_LW   = 4'd1,  K_SW   = 4'd2,
                         K_BEQ  = 4'd3,  K_BNE  = 4'd4,  K_BGTZ = 4'd5,
                         K_BLEZ = 4'd6,  K_BLTZ = 4'd7,  K_BGEZ = 4'd8,
                         K_ADDI = 4'd9,  K_ANDI = 4'd10, K_XORI = 4'd11,
                         K_ORI  = 4'd12, K_LUI  = 4'd13, K_SLTI = 4'd14,
                         K_J    = 4'd15;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic              accept;
  logic              addr_last;
  logic              restart;
  logic [ADDR_W-1:0] tgt;
  logic [15:0]       off16;
  logic              is_branch;
  logic              oor;
  logic [31:0]       word;

  assign accept    = cmd_valid & cmd_ready;
  assign addr_last = &addr;
  assign restart   = start & (state != S_LOAD);
  // branch/jump targets are word addresses; widen or trim to the address width
  assign tgt       = ADDR_W'(cmd_imm);
  assign is_branch = (cmd_kind >= K_BEQ) && (cmd_kind <= K_BGEZ);

`ifdef INST_ENC_RANGE_CHECK_EN
  logic [ADDR_W:0] off_w;
  logic [31:0]     off32;
  // offset taken one bit wider than the address so addr+1 never wraps
  always_comb begin
    off_w = {1'b0, tgt} - ({1'b0, addr} + {{ADDR_W{1'b0}}, 1'b1});
    off32 = {{(31-ADDR_W){off_w[ADDR_W]}}, off_w};
    off16 = off32[15:0];
    oor   = !((off32[31:15] == '0) || (off32[31:15] == '1));
  end
`else
  // only the low 16 bits of the difference are ever emitted
  always_comb begin
    off16 = 16'({1'b0, tgt} - ({1'b0, addr} + {{ADDR_W{1'b0}}, 1'b1}));
    oor   = 1'b0;
  end
`endif

  // instruction word assembly from command class and fields
  always_comb begin
    word = '0;
    unique case (cmd_kind)
      K_R:    word = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'b00000, cmd_funct};
      K_LW:   word = {6'b100011, cmd_rs, cmd_rt, cmd_imm[15:0]};
      K_SW:   word = {6'b101011, cmd_rs, cmd_rt, cmd_imm[15:0]};
      K_BEQ:  word = {6'b000100, cmd_rs, cmd_rt, off16};
      K_BNE:  word = {6'b000101, cmd_rs, cmd_rt, off16};
      K_BGTZ: word = {6'b000111, cmd_rs, 5'b00000, off16};
      K_BLEZ: word = {6'b000110, cmd_rs, 5'b00000, off16};
      K_BLTZ: word = {6'b000001, cmd_rs, 5'b00000, off16};
      K_BGEZ: word = {6'b000001, cmd_rs, 5'b00001, off16};
      K_ADDI: word = {6'b001000, cmd_rs, cmd_rt, cmd_imm[15:0]};
      K_ANDI: word = {6'b001100, cmd_rs, cmd_rt, cmd_imm[15:0]};
      K_XORI: word = {6'b001110, cmd_rs, cmd_rt, cmd_imm[15:0]};
      K_ORI:  word = {6'b001101, cmd_rs, cmd_rt, cmd_imm[15:0]};
      K_LUI:  word = {6'b001111, 5'b00000, cmd_rt, cmd_imm[15:0]};
      K_SLTI: word = {6'b001010, cmd_rs, cmd_rt, cmd_imm[15:0]};
      K_J:    word = {6'b000010, cmd_imm};
      default: word = '0;
    endcase
    // an unreachable branch becomes a NOP rather than a wrong jump
    if (is_branch && oor) word = '0;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // next state: the session ends on the last command or on address wrap
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (start) state_nx = S_LOAD;
      S_LOAD: if (accept && (cmd_last || addr_last)) state_nx = S_DONE;
      S_DONE: if (start) state_nx = S_LOAD;
      default: state_nx = S_IDLE;
    endcase
  end

  // handshake and status outputs follow the state directly
  always_comb begin
    cmd_ready = (state == S_LOAD);
    busy      = (state == S_LOAD);
  end

  // write port, address/count tracking and sticky session flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr       <= '0;
      count      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      imem_we <= accept;
      done    <= (state == S_DONE) && !start;
      if (accept) begin
        imem_addr  <= addr;
        imem_wdata <= word;
        addr       <= addr + 1'b1;
        count      <= count + 1'b1;
        if (addr_last) ovf <= 1'b1;
      end
      if (restart) begin
        addr  <= base_addr;
        count <= '0;
        ovf   <= 1'b0;
      end
    end
  end

`ifdef INST_ENC_RANGE_CHECK_EN
  // sticky out-of-range branch flag, cleared when a new session starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   err <= 1'b0;
    else if (restart)             err <= 1'b0;
    else if (accept && is_branch && oor) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule
